h4_secded_pipe_n_k: RTL and testbench
=====================================

# h4_secded_pipe_n_k

Pipelined, parametrised SECDED (extended Hamming) decoder with valid/ready flow control and saturating error counters. It is the successor to the combinational single-error-correcting Hamming corrector: it adds an overall parity bit for double-error detection, data extraction, backpressure, and error statistics. It sits on protected link and register paths, between the deserialising receiver and the consumer logic, and it feeds its counters to slow-control.

## Interface
- `n`, 16: codeword width, including the overall parity bit. Legal when n-1 ≤ 2^r − 1, where r = n−1−k.
- `k`, 11: data width. Shortened codes (n−1 < 2^r − 1) are supported.
- `CNT_W`, 16: width of each error counter.
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `hamming_i`  in  n: received codeword.
- `valid_i`  in  1: `hamming_i` is valid.
- `ready_o`  out  1: decoder accepts input this cycle.
- `data_o`  out  k: corrected (or, on DED, uncorrected) data bits.
- `hamming_corrected_o`  out  n: corrected codeword.
- `sec_o`  out  1: single error corrected on this output word.
- `ded_o`  out  1: uncorrectable error detected on this output word.
- `valid_o`  out  1: output word valid.
- `ready_i`  in  1: downstream accepts output.
- `clear_cnt_i`  in  1: synchronous clear of both counters.
- `sec_count_o`  out  CNT_W: saturating count of accepted SEC words.
- `ded_count_o`  out  CNT_W: saturating count of accepted DED words.

## Operation
- **Code layout.** `hamming_i[n-2:0]` is a Hamming code in which 1-based position p sits at bit p−1. Check bits are at positions 2^j. Data bits fill the non-power-of-two positions in ascending order, so `data_o[0]` = position 3.
- **Overall parity.** `hamming_i[n-1]` is even parity over `hamming_i[n-2:0]`.
- **Stage 1 (S1).** Register the codeword, the syndrome s (r bits, XOR of the positions of set bits), and the overall parity P (XOR of all n bits).
- **Stage 2 (S2): classification.**
  - s=0, P=0: clean. sec=0, ded=0.
  - s=0, P=1: overall-parity-bit error. Flip bit n−1. sec=1.
  - 1 ≤ s ≤ n−1, P=1: flip bit s−1. sec=1.
  - s > n−1, P=1 (shortened code, invalid position): ded=1, no flip.
  - s≠0, P=0: double error. ded=1, no flip.
- **Exclusivity.** `sec_o` and `ded_o` are never both 1.
- **Output on DED.** `data_o` and `hamming_corrected_o` carry the received bits unmodified.
- **Counters.**
  - Update only on an output handshake (`valid_o && ready_i`).
  - `sec_count_o` increments when `sec_o` = 1; `ded_count_o` increments when `ded_o` = 1.
  - Both saturate at 2^CNT_W − 1 and do not wrap.
  - `clear_cnt_i` sets both to 0 on the next edge. Clear beats a simultaneous increment.

## Timing
- **Latency.** Exactly 2 cycles from input handshake to `valid_o` when there is no backpressure.
- **Throughput.** 1 word per cycle.
- **Pipeline advance.** S2 loads when it is empty or `ready_i`=1. S1 loads when it is empty or S2 loads.
- **Ready.** `ready_o` = S1 empty or S2 loads. It is combinational from `ready_i`, and it is 0 while `rst` is high.
- **Stall.** While `valid_o && !ready_i`, all outputs hold stable. No word is dropped or duplicated. Capacity is 2 words.
- **Reset values** (asynchronous, immediate): `valid_o`=0, `data_o`=0, `hamming_corrected_o`=0, `sec_o`=0, `ded_o`=0, both counters 0, both stage valids 0.
- **Reset mid-stream.** In-flight words are discarded. The first input handshake after `rst` falls yields output 2 cycles later.
- **Flags.** `sec_o` and `ded_o` are qualified by `valid_o`. They are 0 whenever `valid_o`=0.

## Test plan
- **Clean words.** Set `ready_i`=1 and stream all 2048 encodings of `data` 0..2047 back-to-back. Required: `data_o` equals the input 2 cycles later, `sec_o`=`ded_o`=0, counters stay 0.
- **Single errors.** Send 16'hFFFF (the encoding of 11'h7FF) with each of the 16 bits flipped in turn. Required: `data_o`=11'h7FF, `hamming_corrected_o`=16'hFFFF, `sec_o`=1, `sec_count_o`=16 at the end.
- **Double errors.** Send 16'h0000 with bits 0 and 5 flipped (16'h0021). Required: `ded_o`=1, `sec_o`=0, `hamming_corrected_o`=16'h0021, `ded_count_o`=1.
- **Backpressure.** Hold `ready_i`=0 while 3 words are offered. Required: `ready_o` drops after 2 accepted words and output holds the first word. On release, all words appear in order, with no counter double-count.
- **Saturation and clear.** With `CNT_W`=2, send 5 SEC words. Required: `sec_count_o`=3. Then assert `clear_cnt_i` on the same cycle as a SEC handshake. Required: count is 0.
- **Mid-stream reset.** Assert `rst` with both stages full. Required: `valid_o`=0 immediately and counters 0. After release, the next word arrives with 2-cycle latency.

Source files
------------

// File: rtl/h4_secded_pipe_n_k.sv
// Two-stage SECDED (extended Hamming) decoder with valid/ready flow control
// and saturating SEC/DED event counters.
module h4_secded_pipe_n_k #(
   parameter int n     = 16,
   parameter int k     = 11,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [n-1:0]     hamming_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [k-1:0]     data_o,
   output logic [n-1:0]     hamming_corrected_o,
   output logic             sec_o,
   output logic             ded_o,
   output logic             valid_o,
   input  logic             ready_i,
   input  logic             clear_cnt_i,
   output logic [CNT_W-1:0] sec_count_o,
   output logic [CNT_W-1:0] ded_count_o
);

   localparam int          R  = n - 1 - k;
   localparam int unsigned NH = n - 1;
   localparam int unsigned KU = k;

   // XOR of the 1-based positions of all set bits in the Hamming part
   function automatic logic [R-1:0] syndrome(input logic [n-1:0] cw);
      logic [R-1:0] s;
      s = '0;
      for (int unsigned p = 1; p <= NH; p++)
         if (cw[p-1]) s ^= R'(p);
      return s;
   endfunction

   // Data bits occupy the non-power-of-two positions in ascending order
   function automatic logic [k-1:0] extract(input logic [n-1:0] cw);
      logic [k-1:0] d;
      int unsigned  idx;
      d   = '0;
      idx = 0;
      for (int unsigned p = 1; p <= NH; p++)
         if ((p & (p - 1)) != 0) begin
            if (idx < KU) d[idx] = cw[p-1];
            idx++;
         end
      return d;
   endfunction

   logic           s1_valid;
   logic [n-1:0]   s1_cw;
   logic [R-1:0]   s1_syn;
   logic           s1_par;

   logic           s1_load;
   logic           s2_load;
   logic           out_hs;

   logic [n-1:0]   flip;
   logic [n-1:0]   corr_cw;
   logic           sec_c;
   logic           ded_c;

   assign s2_load = !valid_o || ready_i;
   assign s1_load = !s1_valid || s2_load;
   assign ready_o = !rst && s1_load;
   assign out_hs  = valid_o && ready_i;

   // Stage 1: capture codeword, syndrome and overall parity
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_cw    <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= valid_i;
         if (valid_i) begin
            s1_cw  <= hamming_i;
            s1_syn <= syndrome(hamming_i);
            s1_par <= ^hamming_i;
         end
      end
   end

   // Classification; flip stays zero on DED so the received bits pass through
   always_comb begin
      flip  = '0;
      sec_c = 1'b0;
      ded_c = 1'b0;
      if (s1_syn == '0) begin
         if (s1_par) begin
            flip[n-1] = 1'b1;
            sec_c     = 1'b1;
         end
      end else if (!s1_par) begin
         ded_c = 1'b1;
      end else if (32'(s1_syn) > NH) begin
         ded_c = 1'b1;
      end else begin
         sec_c = 1'b1;
         for (int unsigned i = 0; i < NH; i++)
            if (32'(s1_syn) == i + 1) flip[i] = 1'b1;
      end
   end

   assign corr_cw = s1_cw ^ flip;

   // Stage 2: output register; flags cleared whenever the stage goes empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_o             <= 1'b0;
         data_o              <= '0;
         hamming_corrected_o <= '0;
         sec_o               <= 1'b0;
         ded_o               <= 1'b0;
      end else if (s2_load) begin
         valid_o <= s1_valid;
         sec_o   <= s1_valid && sec_c;
         ded_o   <= s1_valid && ded_c;
         if (s1_valid) begin
            data_o              <= extract(corr_cw);
            hamming_corrected_o <= corr_cw;
         end
      end
   end

   // Counters advance only on output handshakes; clear has priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_count_o <= '0;
         ded_count_o <= '0;
      end else if (clear_cnt_i) begin
         sec_count_o <= '0;
         ded_count_o <= '0;
      end else if (out_hs) begin
         if (sec_o && (sec_count_o != '1)) sec_count_o <= sec_count_o + CNT_W'(1);
         if (ded_o && (ded_count_o != '1)) ded_count_o <= ded_count_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_h4_secded_pipe_n_k.sv
// Directed bench for h4_secded_pipe_n_k: a 16-bit counter instance and a
// 2-bit counter instance driven by the same stimulus.
module tb_h4_secded_pipe_n_k;

   logic        clk;
   logic        rst;
   logic [15:0] hamming_i;
   logic        valid_i;
   logic        ready_i;
   logic        clear_cnt_i;

   logic        ready_o;
   logic [10:0] data_o;
   logic [15:0] hamming_corrected_o;
   logic        sec_o;
   logic        ded_o;
   logic        valid_o;
   logic [15:0] sec_count_o;
   logic [15:0] ded_count_o;

   logic        d2_ready_o;
   logic [10:0] d2_data_o;
   logic [15:0] d2_hamming_corrected_o;
   logic        d2_sec_o;
   logic        d2_ded_o;
   logic        d2_valid_o;
   logic [1:0]  d2_sec_count_o;
   logic [1:0]  d2_ded_count_o;

   int total = 0;
   int bad   = 0;

   h4_secded_pipe_n_k #(.n(16), .k(11), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .hamming_i(hamming_i), .valid_i(valid_i),
      .ready_o(ready_o), .data_o(data_o), .hamming_corrected_o(hamming_corrected_o),
      .sec_o(sec_o), .ded_o(ded_o), .valid_o(valid_o), .ready_i(ready_i),
      .clear_cnt_i(clear_cnt_i), .sec_count_o(sec_count_o), .ded_count_o(ded_count_o)
   );

   h4_secded_pipe_n_k #(.n(16), .k(11), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .hamming_i(hamming_i), .valid_i(valid_i),
      .ready_o(d2_ready_o), .data_o(d2_data_o), .hamming_corrected_o(d2_hamming_corrected_o),
      .sec_o(d2_sec_o), .ded_o(d2_ded_o), .valid_o(d2_valid_o), .ready_i(ready_i),
      .clear_cnt_i(clear_cnt_i), .sec_count_o(d2_sec_count_o), .ded_count_o(d2_ded_count_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference (16,11) SECDED encoder
   function automatic logic [15:0] enc(input logic [10:0] d);
      logic [15:0] c;
      logic        b;
      int unsigned idx;
      c   = '0;
      idx = 0;
      for (int unsigned p = 1; p <= 15; p++)
         if ((p & (p - 1)) != 0) begin
            c[p-1] = d[idx];
            idx++;
         end
      for (int unsigned j = 0; j < 4; j++) begin
         b = 1'b0;
         for (int unsigned p = 1; p <= 15; p++)
            if (p[j] && ((p & (p - 1)) != 0)) b ^= c[p-1];
         c[(1 << j) - 1] = b;
      end
      c[15] = ^c[14:0];
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] w;
      rst         = 1'b1;
      valid_i     = 1'b0;
      hamming_i   = '0;
      ready_i     = 1'b0;
      clear_cnt_i = 1'b0;

      // Reset state
      #1;
      check("rst_valid", valid_o, 0);
      check("rst_data", data_o, 0);
      check("rst_hc", hamming_corrected_o, 0);
      check("rst_sec", sec_o, 0);
      check("rst_ded", ded_o, 0);
      check("rst_seccnt", sec_count_o, 0);
      check("rst_dedcnt", ded_count_o, 0);
      check("rst_ready", ready_o, 0);
      step;
      rst     = 1'b0;
      ready_i = 1'b1;
      #1;
      check("ready_after_rst", ready_o, 1);

      // Clean words, back-to-back
      for (int i = 0; i < 2050; i++) begin
         if (i < 2048) begin
            valid_i   = 1'b1;
            hamming_i = enc(11'(i));
         end else begin
            valid_i = 1'b0;
         end
         step;
         if (i == 0) check("clean_latency", valid_o, 0);
         if (i >= 1 && i <= 2048) begin
            check("clean_valid", valid_o, 1);
            check("clean_data", data_o, 32'(i - 1));
            check("clean_sec", sec_o, 0);
            check("clean_ded", ded_o, 0);
         end
      end
      check("clean_seccnt", sec_count_o, 0);
      check("clean_dedcnt", ded_count_o, 0);

      // Single errors on 16'hFFFF, one bit each
      for (int i = 0; i < 18; i++) begin
         if (i < 16) begin
            valid_i   = 1'b1;
            hamming_i = 16'hFFFF ^ (16'h1 << i);
         end else begin
            valid_i = 1'b0;
         end
         step;
         if (i >= 1 && i <= 16) begin
            check("sec_data", data_o, 32'h7FF);
            check("sec_hc", hamming_corrected_o, 32'hFFFF);
            check("sec_flag", sec_o, 1);
            check("sec_noded", ded_o, 0);
            check("sec_cnt_run", sec_count_o, 32'(i - 1));
            check("sec_cnt2_run", d2_sec_count_o, (i - 1 > 3) ? 32'd3 : 32'(i - 1));
         end
      end
      check("sec_cnt_end", sec_count_o, 16);
      check("sec_cnt2_sat", d2_sec_count_o, 3);
      check("sec_flag_idle", sec_o, 0);

      // Double error
      valid_i   = 1'b1;
      hamming_i = 16'h0021;
      step;
      valid_i = 1'b0;
      step;
      check("ded_flag", ded_o, 1);
      check("ded_nosec", sec_o, 0);
      check("ded_hc", hamming_corrected_o, 32'h0021);
      check("ded_data", data_o, 32'h004);
      check("ded2_valid", d2_valid_o, 1);
      check("ded2_flag", d2_ded_o, 1);
      check("ded2_nosec", d2_sec_o, 0);
      check("ded2_hc", d2_hamming_corrected_o, 32'h0021);
      check("ded2_data", d2_data_o, 32'h004);
      check("ded2_ready", d2_ready_o, 1);
      step;
      check("ded_cnt", ded_count_o, 1);
      check("ded_cnt2", d2_ded_count_o, 1);
      check("ded_drain", valid_o, 0);

      // Backpressure: three words offered with ready_i low
      ready_i   = 1'b0;
      valid_i   = 1'b1;
      hamming_i = 16'hFFFE;
      #1;
      check("bp_ready_a", ready_o, 1);
      step;
      hamming_i = 16'h0021;
      #1;
      check("bp_ready_b", ready_o, 1);
      step;
      check("bp_valid_a", valid_o, 1);
      check("bp_data_a", data_o, 32'h7FF);
      hamming_i = enc(11'h123);
      #1;
      check("bp_ready_full", ready_o, 0);
      check("bp2_ready_full", d2_ready_o, 0);
      step;
      check("bp_hold_hc", hamming_corrected_o, 32'hFFFF);
      check("bp_hold_sec", sec_o, 1);
      check("bp_hold_cnt", sec_count_o, 16);
      step;
      check("bp_hold_hc2", hamming_corrected_o, 32'hFFFF);
      check("bp_hold_valid", valid_o, 1);
      check("bp_hold_cnt2", sec_count_o, 16);
      ready_i = 1'b1;
      #1;
      check("bp_ready_rel", ready_o, 1);
      step;
      valid_i = 1'b0;
      check("bp_out_b_hc", hamming_corrected_o, 32'h0021);
      check("bp_out_b_ded", ded_o, 1);
      check("bp_out_b_sec", sec_o, 0);
      check("bp_seccnt_a", sec_count_o, 17);
      check("bp_dedcnt_a", ded_count_o, 1);
      step;
      w = enc(11'h123);
      check("bp_out_c_data", data_o, 32'h123);
      check("bp_out_c_hc", hamming_corrected_o, 32'(w));
      check("bp_out_c_sec", sec_o, 0);
      check("bp_out_c_ded", ded_o, 0);
      check("bp_dedcnt_b", ded_count_o, 2);
      step;
      check("bp_drain", valid_o, 0);
      check("bp_seccnt_end", sec_count_o, 17);
      check("bp_dedcnt_end", ded_count_o, 2);
      check("bp_seccnt2_end", d2_sec_count_o, 3);
      check("bp_dedcnt2_end", d2_ded_count_o, 2);

      // Clear on the same edge as a SEC handshake
      valid_i   = 1'b1;
      hamming_i = 16'hFFFE;
      step;
      valid_i = 1'b0;
      step;
      check("clr_pre_sec", sec_o, 1);
      clear_cnt_i = 1'b1;
      step;
      clear_cnt_i = 1'b0;
      check("clr_seccnt", sec_count_o, 0);
      check("clr_dedcnt", ded_count_o, 0);
      check("clr_seccnt2", d2_sec_count_o, 0);
      check("clr_dedcnt2", d2_ded_count_o, 0);
      valid_i   = 1'b1;
      hamming_i = 16'h7FFF;
      step;
      valid_i = 1'b0;
      step;
      check("clr_post_hc", hamming_corrected_o, 32'hFFFF);
      step;
      check("clr_post_cnt", sec_count_o, 1);

      // Mid-stream reset with both stages full
      ready_i   = 1'b0;
      valid_i   = 1'b1;
      hamming_i = 16'hFFFE;
      step;
      hamming_i = 16'h0021;
      step;
      valid_i = 1'b0;
      check("mr_pre_valid", valid_o, 1);
      #2;
      rst = 1'b1;
      #1;
      check("mr_valid", valid_o, 0);
      check("mr_sec", sec_o, 0);
      check("mr_data", data_o, 0);
      check("mr_hc", hamming_corrected_o, 0);
      check("mr_seccnt", sec_count_o, 0);
      check("mr_dedcnt", ded_count_o, 0);
      check("mr_ready", ready_o, 0);
      step;
      rst       = 1'b0;
      ready_i   = 1'b1;
      valid_i   = 1'b1;
      hamming_i = enc(11'h2AA);
      step;
      valid_i = 1'b0;
      check("mr_lat1", valid_o, 0);
      step;
      w = enc(11'h2AA);
      check("mr_lat2", valid_o, 1);
      check("mr_out_data", data_o, 32'h2AA);
      check("mr_out_hc", hamming_corrected_o, 32'(w));
      check("mr_out_sec", sec_o, 0);
      step;
      check("mr_no_ghost", valid_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
